ula_operand_loader: RTL and testbench

Upstream stage of the 2-bit RISC-V-style ULA on the FPGA board. It loads operand A, operand B and the 3-bit ALU control code one after another from the same switch field, each on a debounced rising edge of an "enter" switch. It then presents a stable, validated operand set to the ULA with a valid flag. It also keeps a completed-operation counter and a state code for the LEDs.

---
 rtl/ula_pkg.sv | 42 ++++
 rtl/sync_rise_detect.sv | 29 ++
 rtl/ula_operand_loader.sv | 96 +++++++++
 tb/tb_ula_operand_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the 2-bit ULA and its operand loader:
// loader state codes, ALU control constants and the op legality check.
package ula_pkg;

    localparam int OP_W    = 3;
    localparam int STATE_W = 2;

    // Loader FSM; codes are shown directly on the LEDs
    typedef enum logic [STATE_W-1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        READY   = 2'b11
    } load_state_t;

    // ALU control codes understood by the ULA
    localparam logic [OP_W-1:0] A_E_B      = 3'b000;
    localparam logic [OP_W-1:0] A_OU_B     = 3'b001;
    localparam logic [OP_W-1:0] SOMA       = 3'b010;
    localparam logic [OP_W-1:0] A_E_NAO_B  = 3'b100;
    localparam logic [OP_W-1:0] A_OU_NAO_B = 3'b101;
    localparam logic [OP_W-1:0] SUBTRACAO  = 3'b110;
    localparam logic [OP_W-1:0] SLT        = 3'b111;

    // 011 has no ALU function assigned and must never reach the ULA
    function automatic logic is_legal_op(input logic [OP_W-1:0] code);
        logic ok;
        ok = 1'b0;
        case (code)
            A_E_B,
            A_OU_B,
            SOMA,
            A_E_NAO_B,
            A_OU_NAO_B,
            SUBTRACAO,
            SLT:     ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Three-flop synchronizer for a raw board switch plus a one-cycle rising-edge pulse.
// Ports: clk_2, reset (async, active-high), sw (raw level), rise (pulse, one clock).
module sync_rise_detect (
    input  logic clk_2,
    input  logic reset,
    input  logic sw,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability; s3 holds the previous synchronized level
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/ula_operand_loader.sv
// Loads A, B and the ALU control code from one switch field on successive enter presses.
// Ports: clk_2, reset, data_in, enter, clear -> a, b, op, valid, op_illegal, state_code, op_count.
module ula_operand_loader
    import ula_pkg::*;
#(
    parameter int NBITS_OPERAND = 2,
    parameter int NBITS_OP      = 3,
    parameter int NBITS_IN      = 3,
    parameter int NBITS_COUNT   = 4
) (
    input  logic                     clk_2,
    input  logic                     reset,
    input  logic [NBITS_IN-1:0]      data_in,
    input  logic                     enter,
    input  logic                     clear,
    output logic [NBITS_OPERAND-1:0] a,
    output logic [NBITS_OPERAND-1:0] b,
    output logic [NBITS_OP-1:0]      op,
    output logic                     valid,
    output logic                     op_illegal,
    output logic [1:0]               state_code,
    output logic [NBITS_COUNT-1:0]   op_count
);

    load_state_t               state;
    logic                      rise;
    logic [NBITS_OPERAND-1:0]  operand_in;
    logic [NBITS_OP-1:0]       op_in;
    logic                      op_ok;

    sync_rise_detect u_enter_sync (
        .clk_2 (clk_2),
        .reset (reset),
        .sw    (enter),
        .rise  (rise)
    );

    // High bits of data_in beyond each field are simply not looked at
    assign operand_in = data_in[NBITS_OPERAND-1:0];
    assign op_in      = data_in[NBITS_OP-1:0];
    assign op_ok      = is_legal_op(op_in);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state      <= LOAD_A;
            a          <= '0;
            b          <= '0;
            op         <= '0;
            valid      <= 1'b0;
            op_illegal <= 1'b0;
            op_count   <= '0;
        end else if (clear) begin
            // clear has priority; a coincident rise is dropped
            state      <= LOAD_A;
            a          <= '0;
            b          <= '0;
            op         <= '0;
            valid      <= 1'b0;
            op_illegal <= 1'b0;
        end else if (rise) begin
            unique case (state)
                LOAD_A: begin
                    a          <= operand_in;
                    op_illegal <= 1'b0;
                    state      <= LOAD_B;
                end
                LOAD_B: begin
                    b     <= operand_in;
                    state <= LOAD_OP;
                end
                LOAD_OP: begin
                    if (op_ok) begin
                        // op and valid update together so the ULA never
                        // sees a stale code alongside valid
                        op       <= op_in;
                        valid    <= 1'b1;
                        op_count <= op_count + NBITS_COUNT'(1);
                        state    <= READY;
                    end else begin
                        op_illegal <= 1'b1;
                    end
                end
                READY: begin
                    valid <= 1'b0;
                    state <= LOAD_A;
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

    assign state_code = state;

endmodule

// File: tb/tb_ula_operand_loader.sv
// Scoreboard bench for ula_operand_loader: a small model pushes expected
// output sets on each enter press; they are popped when the load edge has passed.
module tb_ula_operand_loader;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [2:0] data_in;
    logic       enter;
    logic       clear;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] op;
    logic       valid;
    logic       op_illegal;
    logic [1:0] state_code;
    logic [3:0] op_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] op;
        logic       v;
        logic       ill;
        logic [3:0] cnt;
        logic [1:0] st;
    } exp_t;

    exp_t m;
    exp_t q[$];

    ula_operand_loader dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .data_in    (data_in),
        .enter      (enter),
        .clear      (clear),
        .a          (a),
        .b          (b),
        .op         (op),
        .valid      (valid),
        .op_illegal (op_illegal),
        .state_code (state_code),
        .op_count   (op_count)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m = '{a: 2'd0, b: 2'd0, op: 3'd0, v: 1'b0, ill: 1'b0,
              cnt: 4'd0, st: 2'b00};
    endfunction

    function automatic void model_clear();
        m.a   = 2'd0;
        m.b   = 2'd0;
        m.op  = 3'd0;
        m.v   = 1'b0;
        m.ill = 1'b0;
        m.st  = 2'b00;
    endfunction

    function automatic void model_step(input logic [2:0] d);
        case (m.st)
            2'b00: begin m.a = d[1:0]; m.ill = 1'b0; m.st = 2'b01; end
            2'b01: begin m.b = d[1:0]; m.st = 2'b10; end
            2'b10: begin
                if (d == 3'b011) begin
                    m.ill = 1'b1;
                end else begin
                    m.op  = d;
                    m.v   = 1'b1;
                    m.cnt = m.cnt + 4'd1;
                    m.st  = 2'b11;
                end
            end
            default: begin m.v = 1'b0; m.st = 2'b00; end
        endcase
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".a"},   32'(a),          32'(e.a));
        check({tag, ".b"},   32'(b),          32'(e.b));
        check({tag, ".op"},  32'(op),         32'(e.op));
        check({tag, ".v"},   32'(valid),      32'(e.v));
        check({tag, ".ill"}, 32'(op_illegal), 32'(e.ill));
        check({tag, ".cnt"}, 32'(op_count),   32'(e.cnt));
        check({tag, ".st"},  32'(state_code), 32'(e.st));
    endtask

    // enter sampled high at edge k, result must appear at edge k+2, not k+1
    task automatic press(input string tag, input logic [2:0] d);
        exp_t prev;
        exp_t e;
        prev = m;
        @(negedge clk_2);
        data_in = d;
        enter   = 1'b1;
        model_step(d);
        q.push_back(m);
        @(posedge clk_2);
        @(negedge clk_2);
        enter = 1'b0;
        @(posedge clk_2);
        @(negedge clk_2);
        check({tag, ".early_st"}, 32'(state_code), 32'(prev.st));
        check({tag, ".early_v"},  32'(valid),      32'(prev.v));
        @(posedge clk_2);
        @(negedge clk_2);
        e = q.pop_front();
        check_all(tag, e);
    endtask

    int unsigned legal_ops [7] = '{0, 1, 2, 4, 5, 6, 7};

    initial begin
        reset   = 1'b1;
        data_in = 3'd0;
        enter   = 1'b0;
        clear   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_2);
        @(negedge clk_2);
        check_all("por", m);
        reset = 1'b0;

        // reset asserted mid-LOAD_B takes effect without a clock edge
        press("t1_a", 3'd2);
        @(negedge clk_2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("t1_async", m);
        @(negedge clk_2);
        reset = 1'b0;

        // basic load
        press("t2_a", 3'd3);
        press("t2_b", 3'd1);
        press("t2_op", 3'b010);

        // illegal op rejected, then a legal one accepted
        press("t3_ret", 3'd0);
        press("t3_a", 3'd1);
        press("t3_b", 3'd2);
        press("t3_bad", 3'b011);
        press("t3_op", 3'b110);
        press("t3_ret2", 3'd5);

        // holding enter produces a single load
        @(negedge clk_2);
        data_in = 3'b101;
        enter   = 1'b1;
        model_step(3'b101);
        repeat (20) @(posedge clk_2);
        @(negedge clk_2);
        check_all("t4_hold", m);
        enter = 1'b0;
        repeat (3) @(posedge clk_2);
        press("t4_b", 3'd3);

        // clear coincident with rise in LOAD_OP wins and consumes the rise
        @(negedge clk_2);
        data_in = 3'b010;
        enter   = 1'b1;
        @(posedge clk_2);
        @(negedge clk_2);
        enter = 1'b0;
        @(posedge clk_2);
        @(negedge clk_2);
        clear = 1'b1;
        @(posedge clk_2);
        @(negedge clk_2);
        clear = 1'b0;
        model_clear();
        check_all("t5_clr", m);
        @(posedge clk_2);
        @(negedge clk_2);
        check_all("t5_after", m);

        // 16 complete sets: counter wraps through zero
        for (int i = 0; i < 16; i++) begin
            press("t6_a", 3'(i % 4));
            press("t6_b", 3'((i + 1) % 4));
            press("t6_op", 3'(legal_ops[i % 7]));
            press("t6_ret", 3'(i));
        end

        // unused high bit ignored for operands
        press("t7_a", 3'b110);
        press("t7_b", 3'b101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
